// File: rtl/brg_xcel_mem_req_tracker_pkg.sv
// Shared types and helpers for the BRG accelerator memory-request tracker.
package brg_xcel_pkg;

  // Request direction as carried on the accelerator master port.
  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } brg_xcel_req_type_e;

  localparam int unsigned BRG_XCEL_DATA_W = 32;
  localparam int unsigned BRG_XCEL_ADDR_W = 32;

  // Default-configuration view of one accelerator request.
  typedef struct packed {
    logic                         we;
    logic [BRG_XCEL_ADDR_W-1:0]   addr;
    logic [BRG_XCEL_DATA_W-1:0]   data;
    logic [BRG_XCEL_DATA_W/8-1:0] mask;
  } brg_xcel_req_s;

  // Bits needed to name one reorder-buffer entry (at least one bit).
  function automatic int unsigned brg_xcel_tag_width(input int unsigned els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

endpackage

// File: rtl/brg_xcel_mem_req_tracker_tag_rob.sv
// Tag allocator and reorder buffer: hands out load tags at the tail, accepts
// out-of-order returns by tag, and drains data in issue order at the head.
module brg_xcel_tag_rob
  import brg_xcel_pkg::*;
#(
  parameter int unsigned data_width_p    = 32,
  parameter int unsigned load_id_width_p = 11,
  parameter int unsigned els_p           = 8,
  localparam int unsigned tag_w_lp       = brg_xcel_tag_width(els_p),
  localparam int unsigned cnt_w_lp       = $clog2(els_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       alloc_i,
  output logic [tag_w_lp-1:0]        alloc_tag_o,
  output logic                       full_o,
  input  logic                       ret_v_i,
  input  logic [load_id_width_p-1:0] ret_id_i,
  input  logic [data_width_p-1:0]    ret_data_i,
  output logic                       resp_v_o,
  output logic [data_width_p-1:0]    resp_data_o,
  input  logic                       resp_ready_i,
  output logic                       err_o
);

  logic [tag_w_lp-1:0] head_q, head_d;
  logic [tag_w_lp-1:0] tail_q, tail_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic [els_p-1:0]    valid_q, valid_d;
  logic [els_p-1:0]    pending_q, pending_d;
  logic                err_q, err_d;
  logic [data_width_p-1:0] data_q [els_p];

  logic [tag_w_lp-1:0] ret_idx;
  logic                ret_ok;
  logic                drain;

  function automatic logic [tag_w_lp-1:0] wrap_inc(input logic [tag_w_lp-1:0] p);
    return (p == tag_w_lp'(els_p - 1)) ? '0 : p + tag_w_lp'(1);
  endfunction

  // A return is legal only for an in-range tag that is still awaiting data.
  assign ret_idx = ret_id_i[tag_w_lp-1:0];
  assign ret_ok  = ret_v_i & ((ret_id_i >> tag_w_lp) == '0) & pending_q[ret_idx];
  assign drain   = valid_q[head_q] & resp_ready_i;

  assign alloc_tag_o = tail_q;
  assign full_o      = (count_q == cnt_w_lp'(els_p));
  assign resp_v_o    = valid_q[head_q];
  assign resp_data_o = data_q[head_q];
  assign err_o       = err_q;

  // Next-state for pointers, occupancy, per-entry flags and the sticky error.
  // NOTE: always_comb uses blocking '=' with every output defaulted first, so no latch is inferred.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    valid_d   = valid_q;
    pending_d = pending_q;
    err_d     = err_q;

    if (ret_ok) begin
      valid_d[ret_idx]   = 1'b1;
      pending_d[ret_idx] = 1'b0;
    end else if (ret_v_i) begin
      err_d = 1'b1;
    end

    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = wrap_inc(head_q);
    end

    if (alloc_i) begin
      pending_d[tail_q] = 1'b1;
      valid_d[tail_q]   = 1'b0;
      tail_d            = wrap_inc(tail_q);
    end

    unique case ({alloc_i, drain})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  // NOTE: sequential state uses non-blocking '<=' so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  // Returned-data storage, written only by an accepted return.
  // NOTE: the data array has no reset; its contents are meaningless until the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (ret_ok) data_q[ret_idx] <= ret_data_i;
  end

endmodule

// File: rtl/brg_xcel_mem_req_tracker.sv
// BRG accelerator memory-request tracker: tags loads, gates issue on endpoint
// credits and reorder space, and returns load data in issue order.
// Optional statistics counters: define BRG_XCEL_TRACKER_STATS_EN.
module brg_xcel_mem_req_tracker
  import brg_xcel_pkg::*;
#(
  parameter int unsigned data_width_p      = 32,
  parameter int unsigned addr_width_p      = 32,
  parameter int unsigned load_id_width_p   = 11,
  parameter int unsigned els_p             = 8,
  parameter int unsigned max_out_credits_p = 200,
  localparam int unsigned credit_w_lp      = $clog2(max_out_credits_p + 1),
  localparam int unsigned tag_w_lp         = brg_xcel_tag_width(els_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        req_v_i,
  output logic                        req_ready_o,
  input  logic                        req_we_i,
  input  logic [addr_width_p-1:0]     req_addr_i,
  input  logic [data_width_p-1:0]     req_data_i,
  input  logic [data_width_p/8-1:0]   req_mask_i,
  output logic                        resp_v_o,
  output logic [data_width_p-1:0]     resp_data_o,
  input  logic                        resp_ready_i,
  output logic                        out_v_o,
  output logic                        out_we_o,
  output logic [addr_width_p-1:0]     out_addr_o,
  output logic [data_width_p-1:0]     out_data_o,
  output logic [data_width_p/8-1:0]   out_mask_o,
  output logic [load_id_width_p-1:0]  out_opq_o,
  input  logic                        out_ready_i,
  input  logic [credit_w_lp-1:0]      out_credits_i,
  input  logic                        returned_v_i,
  input  logic [load_id_width_p-1:0]  returned_load_id_i,
  input  logic [data_width_p-1:0]     returned_data_i,
  output logic                        err_o
`ifdef BRG_XCEL_TRACKER_STATS_EN
 ,output logic [31:0]                 stat_loads_o,
  output logic [31:0]                 stat_stores_o,
  output logic [31:0]                 stat_stall_o
`endif
);

  brg_xcel_req_type_e  req_type;
  logic                is_load;
  logic                rob_full;
  logic                can_issue;
  logic                fire;
  logic                load_fire;
  logic [tag_w_lp-1:0] alloc_tag;

  // Stores only need a credit; loads also need a free reorder entry. A drain
  // in the same cycle does not open a slot for a load.
  assign req_type  = brg_xcel_req_type_e'(req_we_i);
  assign is_load   = (req_type == LOAD);
  assign can_issue = (out_credits_i != '0) & (~is_load | ~rob_full);

  assign out_v_o     = req_v_i & can_issue;
  assign req_ready_o = out_ready_i & can_issue;
  assign fire        = req_v_i & req_ready_o;
  assign load_fire   = fire & is_load;

  assign out_we_o   = req_we_i;
  assign out_addr_o = req_addr_i;
  assign out_data_o = req_data_i;
  assign out_mask_o = req_mask_i;
  assign out_opq_o  = is_load ? load_id_width_p'(alloc_tag) : '0;

  brg_xcel_tag_rob #(
    .data_width_p    (data_width_p),
    .load_id_width_p (load_id_width_p),
    .els_p           (els_p)
  ) u_rob (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .alloc_i      (load_fire),
    .alloc_tag_o  (alloc_tag),
    .full_o       (rob_full),
    .ret_v_i      (returned_v_i),
    .ret_id_i     (returned_load_id_i),
    .ret_data_i   (returned_data_i),
    .resp_v_o     (resp_v_o),
    .resp_data_o  (resp_data_o),
    .resp_ready_i (resp_ready_i),
    .err_o        (err_o)
  );

`ifdef BRG_XCEL_TRACKER_STATS_EN
  logic [31:0] stat_loads_q;
  logic [31:0] stat_stores_q;
  logic [31:0] stat_stall_q;

  // Saturating event counters for loads, stores and stalled request cycles.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (load_fire && stat_loads_q != '1) stat_loads_q <= stat_loads_q + 32'd1;
      if (fire && !is_load && stat_stores_q != '1) stat_stores_q <= stat_stores_q + 32'd1;
      if (req_v_i && !req_ready_o && stat_stall_q != '1) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_loads_o  = stat_loads_q;
  assign stat_stores_o = stat_stores_q;
  assign stat_stall_o  = stat_stall_q;
`endif

endmodule

// File: tb/tb_brg_xcel_mem_req_tracker.sv
// Self-checking bench for brg_xcel_mem_req_tracker: directed scenarios plus a
// randomized phase, all compared against an entry-table reference model.
module tb_brg_xcel_mem_req_tracker;

  localparam int ELS = 8;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int IDW = 11;
  localparam int CW  = $clog2(200 + 1);

  logic            clk;
  logic            reset_n;
  logic            req_v, req_we, resp_ready, out_ready, rv;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_data, rdata;
  logic [DW/8-1:0] req_mask;
  logic [IDW-1:0]  rid;
  logic [CW-1:0]   credits;

  logic            req_ready_o, resp_v_o, out_v_o, out_we_o, err_o;
  logic [DW-1:0]   resp_data_o, out_data_o;
  logic [AW-1:0]   out_addr_o;
  logic [DW/8-1:0] out_mask_o;
  logic [IDW-1:0]  out_opq_o;

  brg_xcel_mem_req_tracker dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .req_v_i            (req_v),
    .req_ready_o        (req_ready_o),
    .req_we_i           (req_we),
    .req_addr_i         (req_addr),
    .req_data_i         (req_data),
    .req_mask_i         (req_mask),
    .resp_v_o           (resp_v_o),
    .resp_data_o        (resp_data_o),
    .resp_ready_i       (resp_ready),
    .out_v_o            (out_v_o),
    .out_we_o           (out_we_o),
    .out_addr_o         (out_addr_o),
    .out_data_o         (out_data_o),
    .out_mask_o         (out_mask_o),
    .out_opq_o          (out_opq_o),
    .out_ready_i        (out_ready),
    .out_credits_i      (credits),
    .returned_v_i       (rv),
    .returned_load_id_i (rid),
    .returned_data_i    (rdata),
    .err_o              (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one record per reorder entry plus ring positions.
  bit          m_pend [ELS];
  bit          m_val  [ELS];
  logic [DW-1:0] m_data [ELS];
  int          m_head, m_tail, m_cnt;
  bit          m_err;
  logic [DW-1:0] dut_resp_q [$];

  task automatic model_clear();
    for (int i = 0; i < ELS; i++) begin
      m_pend[i] = 1'b0;
      m_val[i]  = 1'b0;
    end
    m_head = 0; m_tail = 0; m_cnt = 0; m_err = 1'b0;
  endtask

  task automatic idle();
    req_v = 1'b0; req_we = 1'b0; rv = 1'b0; resp_ready = 1'b0;
  endtask

  // Called just after a falling edge with inputs set: check, advance model, move one cycle.
  task automatic tick();
    bit can, fire, drn;
    #1;
    can  = (credits != 0) && (req_we || m_cnt != ELS);
    fire = req_v && out_ready && can;
    check("out_v", out_v_o, req_v && can);
    check("req_ready", req_ready_o, out_ready && can);
    if (req_v && can) begin
      check("opq", out_opq_o, req_we ? 0 : m_tail);
      check("out_addr", out_addr_o, req_addr);
      check("out_fields", {out_we_o, out_data_o, out_mask_o}, {req_we, req_data, req_mask});
    end
    check("resp_v", resp_v_o, m_val[m_head]);
    if (m_val[m_head]) check("resp_data", resp_data_o, m_data[m_head]);
    check("err", err_o, m_err);
    if (resp_v_o && resp_ready) dut_resp_q.push_back(resp_data_o);

    drn = m_val[m_head] && resp_ready;
    if (rv) begin
      if (rid < ELS && m_pend[rid]) begin
        m_data[rid] = rdata;
        m_val[rid]  = 1'b1;
        m_pend[rid] = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    if (drn) begin
      m_val[m_head] = 1'b0;
      m_head = (m_head + 1) % ELS;
      m_cnt--;
    end
    if (fire && !req_we) begin
      m_pend[m_tail] = 1'b1;
      m_val[m_tail]  = 1'b0;
      m_tail = (m_tail + 1) % ELS;
      m_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_resp_v", resp_v_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic load(input logic [AW-1:0] a);
    req_v = 1'b1; req_we = 1'b0; req_addr = a;
  endtask

  task automatic ret(input int id, input logic [DW-1:0] d);
    rv = 1'b1; rid = IDW'(id); rdata = d;
  endtask

  initial begin
    int pl [$];
    reset_n = 1'b0;
    idle();
    req_addr = '0; req_data = '0; req_mask = '0; rid = '0; rdata = '0;
    out_ready = 1'b1; credits = CW'(5);
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    check("rst_resp_v0", resp_v_o, 1'b0);
    check("rst_err0", err_o, 1'b0);
    check("rst_ready0", req_ready_o, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    // Single load, return, in-order response.
    load(32'h100); tick();
    idle(); ret(0, 32'hDEADBEEF); tick();
    idle(); resp_ready = 1'b1; dut_resp_q.delete(); tick();
    check("t1_resp", (dut_resp_q.size() == 1) ? dut_resp_q[0] : 32'hX, 32'hDEADBEEF);
    idle(); tick();

    // Out-of-order returns reordered to issue order.
    do_reset();
    for (int i = 0; i < 3; i++) begin load(32'h200 + 4 * i); tick(); end
    idle(); ret(2, 32'hA2); tick();
    idle(); ret(0, 32'hA0); tick();
    idle(); ret(1, 32'hA1); tick();
    idle(); resp_ready = 1'b1; dut_resp_q.delete();
    repeat (4) tick();
    check("t2_count", dut_resp_q.size(), 3);
    if (dut_resp_q.size() == 3) begin
      check("t2_r0", dut_resp_q[0], 32'hA0);
      check("t2_r1", dut_resp_q[1], 32'hA1);
      check("t2_r2", dut_resp_q[2], 32'hA2);
    end

    // Fill all entries, blocked load, store still passes, wrap to tag 0.
    do_reset(); idle();
    for (int i = 0; i < ELS; i++) begin load(32'h300 + 4 * i); tick(); end
    load(32'h400); #1; check("full_blocks", req_ready_o, 1'b0); tick();
    req_we = 1'b1; req_data = 32'h1234; req_mask = 4'hF; #1;
    check("store_opq", out_opq_o, '0); tick();
    idle(); ret(0, 32'h77); tick();
    idle(); resp_ready = 1'b1; load(32'h404); tick();   // drain same cycle: load still blocked
    idle(); load(32'h408); #1; check("wrap_tag", out_opq_o, '0); tick();
    idle(); tick();

    // Credit gating.
    do_reset(); idle();
    credits = '0; load(32'h500); #1;
    check("nocred_v", out_v_o, 1'b0);
    check("nocred_rdy", req_ready_o, 1'b0);
    tick();
    credits = CW'(1); tick();
    idle(); credits = CW'(5); tick();

    // Response held while the accelerator stalls.
    do_reset(); idle();
    load(32'h600); tick();
    idle(); ret(0, 32'h5A5A1234); tick();
    idle();
    repeat (4) begin
      #1; check("hold_data", resp_data_o, 32'h5A5A1234); tick();
    end
    resp_ready = 1'b1; tick();
    idle(); tick();

    // Randomized traffic.
    do_reset(); idle();
    for (int c = 0; c < 3000; c++) begin
      req_v      = ($urandom_range(0, 9) < 7);
      req_we     = ($urandom_range(0, 9) < 3);
      req_addr   = $urandom;
      req_data   = $urandom;
      req_mask   = 4'($urandom);
      credits    = CW'($urandom_range(0, 4));
      out_ready  = ($urandom_range(0, 9) < 8);
      resp_ready = ($urandom_range(0, 9) < 6);
      pl.delete();
      for (int i = 0; i < ELS; i++) if (m_pend[i]) pl.push_back(i);
      rv = 1'b0;
      if (pl.size() != 0 && $urandom_range(0, 1) == 1)
        ret(pl[$urandom_range(0, pl.size() - 1)], $urandom);
      tick();
    end

    // Protocol errors: unknown tag, upper tag bits, reset clears, stale tag.
    do_reset(); idle(); out_ready = 1'b1; credits = CW'(5);
    ret(5, 32'h55); tick();
    idle(); repeat (2) tick();
    do_reset(); idle();
    load(32'h700); tick();
    idle(); ret(11'h400, 32'h66); tick();
    idle(); tick();
    load(32'h704); tick();
    idle(); do_reset();
    idle(); ret(1, 32'h88); tick();
    idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
